// File: rtl/seven_seg_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | seven_seg_pkg: seven-segment pattern constants and FSM encoding       |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
package seven_seg_pkg;

  // Segment order A..G maps to bits 6..0
  localparam logic [6:0] c_SEG_0     = 7'b1111110;
  localparam logic [6:0] c_SEG_1     = 7'b0110000;
  localparam logic [6:0] c_SEG_2     = 7'b1101101;
  localparam logic [6:0] c_SEG_3     = 7'b1111001;
  localparam logic [6:0] c_SEG_4     = 7'b0110011;
  localparam logic [6:0] c_SEG_5     = 7'b1011011;
  localparam logic [6:0] c_SEG_6     = 7'b1011111;
  localparam logic [6:0] c_SEG_7     = 7'b1110000;
  localparam logic [6:0] c_SEG_8     = 7'b1111111;
  localparam logic [6:0] c_SEG_9     = 7'b1110011;
  localparam logic [6:0] c_SEG_DASH  = 7'b0000001;
  localparam logic [6:0] c_SEG_BLANK = 7'b0000000;

  localparam logic [3:0] c_VAL_DASH    = 4'hA;
  localparam logic [3:0] c_VAL_INVALID = 4'hF;

  localparam logic [0:0] c_ST_SETTLE = 1'b0;
  localparam logic [0:0] c_ST_LOCKED = 1'b1;

endpackage
`default_nettype wire

// File: rtl/seg_pattern_decode.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | seg_pattern_decode: combinational segment pattern to value lookup     |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module seg_pattern_decode
  import seven_seg_pkg::*;
(
  input  logic [6:0] i_Pattern,
  output logic [3:0] o_Value,
  output logic       o_Dash,
  output logic       o_Blank,
  output logic       o_Invalid
);

  always_comb begin
    o_Value   = 4'h0;
    o_Dash    = 1'b0;
    o_Blank   = 1'b0;
    o_Invalid = 1'b0;
    case (i_Pattern)
      c_SEG_0:     o_Value = 4'd0;
      c_SEG_1:     o_Value = 4'd1;
      c_SEG_2:     o_Value = 4'd2;
      c_SEG_3:     o_Value = 4'd3;
      c_SEG_4:     o_Value = 4'd4;
      c_SEG_5:     o_Value = 4'd5;
      c_SEG_6:     o_Value = 4'd6;
      c_SEG_7:     o_Value = 4'd7;
      c_SEG_8:     o_Value = 4'd8;
      c_SEG_9:     o_Value = 4'd9;
      c_SEG_DASH: begin
        o_Value = c_VAL_DASH;
        o_Dash  = 1'b1;
      end
      c_SEG_BLANK: o_Blank = 1'b1;
      default: begin
        o_Value   = c_VAL_INVALID;
        o_Invalid = 1'b1;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/seven_seg_to_binary.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | seven_seg_to_binary: debounced seven-segment pattern to binary value  |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module seven_seg_to_binary
  import seven_seg_pkg::*;
#(
  parameter int STABLE_CYCLES = 4
) (
  input  logic       i_Clk,
  input  logic       i_Rst,
  input  logic       i_Seg_A,
  input  logic       i_Seg_B,
  input  logic       i_Seg_C,
  input  logic       i_Seg_D,
  input  logic       i_Seg_E,
  input  logic       i_Seg_F,
  input  logic       i_Seg_G,
  output logic [3:0] o_Binary_Num,
  output logic       o_Valid,
  output logic       o_Dash,
  output logic       o_Blank,
  output logic       o_Invalid
);

  localparam int              CNT_W      = $clog2(STABLE_CYCLES) + 1;
  localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  logic [6:0]       w_pattern;
  logic [6:0]       r_Sample;
  logic [6:0]       w_sample_next;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_count_next;
  logic [0:0]       r_state;
  logic [0:0]       w_state_next;
  logic             w_commit;

  logic [3:0]       w_dec_value;
  logic             w_dec_dash;
  logic             w_dec_blank;
  logic             w_dec_invalid;

  logic [3:0]       r_num;
  logic             r_valid;
  logic             r_dash;
  logic             r_blank;
  logic             r_invalid;
  logic [3:0]       w_num_next;
  logic             w_valid_next;
  logic             w_dash_next;
  logic             w_blank_next;
  logic             w_invalid_next;

  assign w_pattern = {i_Seg_A, i_Seg_B, i_Seg_C, i_Seg_D, i_Seg_E, i_Seg_F, i_Seg_G};

  // Decode the held sample, which is what gets committed
  seg_pattern_decode u_decode (
    .i_Pattern (r_Sample),
    .o_Value   (w_dec_value),
    .o_Dash    (w_dec_dash),
    .o_Blank   (w_dec_blank),
    .o_Invalid (w_dec_invalid)
  );

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      r_state  <= c_ST_LOCKED;
      r_Sample <= c_SEG_BLANK;
      r_count  <= '0;
    end else begin
      r_state  <= w_state_next;
      r_Sample <= w_sample_next;
      r_count  <= w_count_next;
    end
  end

  // Any change restarts settling, even out of LOCKED
  always_comb begin
    w_state_next  = r_state;
    w_sample_next = r_Sample;
    w_count_next  = r_count;
    w_commit      = 1'b0;
    if (w_pattern != r_Sample) begin
      w_sample_next = w_pattern;
      w_count_next  = '0;
      w_state_next  = c_ST_SETTLE;
    end else if (r_state == c_ST_SETTLE) begin
      if (r_count == c_CNT_LAST) begin
        w_commit     = 1'b1;
        w_state_next = c_ST_LOCKED;
      end else begin
        w_count_next = r_count + CNT_W'(1);
      end
    end
  end

  always_comb begin
    w_num_next     = r_num;
    w_dash_next    = r_dash;
    w_blank_next   = r_blank;
    w_invalid_next = r_invalid;
    w_valid_next   = 1'b0;
    if (w_commit) begin
      w_num_next     = w_dec_value;
      w_dash_next    = w_dec_dash;
      w_blank_next   = w_dec_blank;
      w_invalid_next = w_dec_invalid;
      w_valid_next   = 1'b1;
    end
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      r_num     <= 4'h0;
      r_valid   <= 1'b0;
      r_dash    <= 1'b0;
      r_blank   <= 1'b0;
      r_invalid <= 1'b0;
    end else begin
      r_num     <= w_num_next;
      r_valid   <= w_valid_next;
      r_dash    <= w_dash_next;
      r_blank   <= w_blank_next;
      r_invalid <= w_invalid_next;
    end
  end

  assign o_Binary_Num = r_num;
  assign o_Valid      = r_valid;
  assign o_Dash       = r_dash;
  assign o_Blank      = r_blank;
  assign o_Invalid    = r_invalid;

endmodule
`default_nettype wire

// File: tb/tb_seven_seg_to_binary.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_seven_seg_to_binary: directed bench with run-length reference model|
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module tb_seven_seg_to_binary;

  logic       clk;
  logic       rst;
  logic [6:0] seg;
  logic       checking;
  int         total;
  int         bad;

  logic [3:0] num4, num1;
  logic       val4, val1, dash4, dash1, blank4, blank1, inv4, inv1;

  seven_seg_to_binary #(.STABLE_CYCLES(4)) dut4 (
    .i_Clk(clk), .i_Rst(rst),
    .i_Seg_A(seg[6]), .i_Seg_B(seg[5]), .i_Seg_C(seg[4]), .i_Seg_D(seg[3]),
    .i_Seg_E(seg[2]), .i_Seg_F(seg[1]), .i_Seg_G(seg[0]),
    .o_Binary_Num(num4), .o_Valid(val4), .o_Dash(dash4), .o_Blank(blank4), .o_Invalid(inv4)
  );

  seven_seg_to_binary #(.STABLE_CYCLES(1)) dut1 (
    .i_Clk(clk), .i_Rst(rst),
    .i_Seg_A(seg[6]), .i_Seg_B(seg[5]), .i_Seg_C(seg[4]), .i_Seg_D(seg[3]),
    .i_Seg_E(seg[2]), .i_Seg_F(seg[1]), .i_Seg_G(seg[0]),
    .o_Binary_Num(num1), .o_Valid(val1), .o_Dash(dash1), .o_Blank(blank1), .o_Invalid(inv1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [6:0] digit_pat [10] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
                                 7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1110011};

  // Reference: a pattern commits once it has been seen on S+1 consecutive edges
  localparam int BIG = 1000;
  int         stab [2] = '{4, 1};
  logic [6:0] m_prev;
  int         m_run   [2];
  logic [3:0] m_num   [2];
  logic       m_valid [2];
  logic       m_dash  [2];
  logic       m_blank [2];
  logic       m_inv   [2];

  always @(posedge clk) begin
    if (rst) begin
      m_prev = 7'b0000000;
      for (int i = 0; i < 2; i++) begin
        m_run[i] = BIG; m_num[i] = 4'h0; m_valid[i] = 0;
        m_dash[i] = 0; m_blank[i] = 0; m_inv[i] = 0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (seg != m_prev) m_run[i] = 1;
        else if (m_run[i] < BIG) m_run[i] = m_run[i] + 1;
        m_valid[i] = 0;
        if (m_run[i] == stab[i] + 1) begin
          m_valid[i] = 1;
          m_dash[i] = (seg == 7'b0000001);
          m_blank[i] = (seg == 7'b0000000);
          m_inv[i] = 1;
          m_num[i] = 4'hF;
          if (m_dash[i]) begin m_num[i] = 4'hA; m_inv[i] = 0; end
          if (m_blank[i]) begin m_num[i] = 4'h0; m_inv[i] = 0; end
          for (int d = 0; d < 10; d++)
            if (digit_pat[d] == seg) begin m_num[i] = 4'(d); m_inv[i] = 0; end
        end
      end
      m_prev = seg;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (checking) begin
      chk("s4_num",   32'(num4),   32'(m_num[0]));
      chk("s4_valid", 32'(val4),   32'(m_valid[0]));
      chk("s4_dash",  32'(dash4),  32'(m_dash[0]));
      chk("s4_blank", 32'(blank4), 32'(m_blank[0]));
      chk("s4_inv",   32'(inv4),   32'(m_inv[0]));
      chk("s1_num",   32'(num1),   32'(m_num[1]));
      chk("s1_valid", 32'(val1),   32'(m_valid[1]));
      chk("s1_dash",  32'(dash1),  32'(m_dash[1]));
      chk("s1_blank", 32'(blank1), 32'(m_blank[1]));
      chk("s1_inv",   32'(inv1),   32'(m_inv[1]));
    end
  end

  task automatic hold(input logic [6:0] p, input int n);
    seg = p;
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic lit4(input string name, input logic v, input logic [3:0] n,
                      input logic d, input logic b, input logic iv);
    chk({name, "_valid"}, 32'(val4), 32'(v));
    chk({name, "_num"},   32'(num4), 32'(n));
    chk({name, "_flags"}, 32'({dash4, blank4, inv4}), 32'({d, b, iv}));
  endtask

  // Round-trip table: pattern, value, {dash, blank, invalid}
  logic [6:0] rt_pat [16] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
                              7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1110011,
                              7'b0000001, 7'b0000000, 7'b1010101, 7'b0000010, 7'b1000000,
                              7'b1111101};
  logic [3:0] rt_val [16] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'h9,
                              4'hA, 4'h0, 4'hF, 4'hF, 4'hF, 4'hF};
  logic [2:0] rt_flg [16] = '{3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000,
                              3'b000, 3'b000, 3'b100, 3'b010, 3'b001, 3'b001, 3'b001, 3'b001};

  initial begin
    total = 0; bad = 0; checking = 0;
    rst = 1'b1; seg = 7'b0000000;
    @(posedge clk); #2;
    checking = 1;
    hold(7'b0000000, 1);
    lit4("reset", 0, 4'h0, 0, 0, 0);
    rst = 1'b0;

    // Digit 2 commits after the fifth edge it is seen
    hold(7'b1101101, 4);
    lit4("two_early", 0, 4'h0, 0, 0, 0);
    hold(7'b1101101, 1);
    lit4("two_commit", 1, 4'h2, 0, 0, 0);
    hold(7'b1101101, 1);
    lit4("two_hold", 0, 4'h2, 0, 0, 0);

    // Short 0 is discarded, 1 commits
    hold(7'b1111110, 3);
    lit4("zero_short", 0, 4'h2, 0, 0, 0);
    hold(7'b0110000, 4);
    lit4("one_early", 0, 4'h2, 0, 0, 0);
    hold(7'b0110000, 1);
    lit4("one_commit", 1, 4'h1, 0, 0, 0);

    hold(7'b0000001, 5);
    lit4("dash", 1, 4'hA, 1, 0, 0);
    hold(7'b1010101, 5);
    lit4("invalid", 1, 4'hF, 0, 0, 1);

    // Glitch then resettle to the same 8
    hold(7'b1111111, 5);
    lit4("eight", 1, 4'h8, 0, 0, 0);
    hold(7'b0111111, 1);
    hold(7'b1111111, 4);
    lit4("eight_resettle", 0, 4'h8, 0, 0, 0);
    hold(7'b1111111, 1);
    lit4("eight_again", 1, 4'h8, 0, 0, 0);

    // Reset lands on the commit edge
    hold(7'b1110000, 4);
    rst = 1'b1;
    hold(7'b1110000, 1);
    lit4("rst_on_commit", 0, 4'h0, 0, 0, 0);
    rst = 1'b0;
    hold(7'b0000000, 6);
    lit4("blank_after_rst", 0, 4'h0, 0, 0, 0);
    hold(7'b0110011, 4);
    lit4("four_early", 0, 4'h0, 0, 0, 0);
    hold(7'b0110011, 1);
    lit4("four_commit", 1, 4'h4, 0, 0, 0);

    // Single-edge settling round trip
    for (int i = 0; i < 16; i++) begin
      hold(rt_pat[i], 1);
      chk("rt_load_valid", 32'(val1), 32'd0);
      hold(rt_pat[i], 1);
      chk("rt_valid", 32'(val1), 32'd1);
      chk("rt_num",   32'(num1), 32'(rt_val[i]));
      chk("rt_flags", 32'({dash1, blank1, inv1}), 32'(rt_flg[i]));
    end

    hold(7'b0000000, 3);
    checking = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
